sram_pixel_decoder: RTL and testbench
=====================================

// Module: sram_pixel_decoder
// PURPOSE
//  Read-side counterpart of the SRAM address encoder. The encoder turns (object id, pixel index)
//  into a word address. This block takes the 16-bit SRAM read word that comes back and keeps the
//  request's pixel-index low bits and object id in step with it.
//  It extracts the 4-bit pixel, flags transparency and maps the pixel through a per-object palette
//  to 24-bit RGB for the VGA compositor.
//  Sits between the SRAM data bus and the frame compositor.
// PARAMETERS
//  DQ_DELAY          1    cycles from request accept (t) until i_sram_dq carries its word (encoder reg = 1)
//  NIBBLE_MSB_FIRST  0    0: pixel k of a word = dq[4k+3:4k]; 1: pixel k = dq[15-4k:12-4k]
//  TRANSPARENT_IDX   4'h0 palette index treated as transparent for sprite objects
// PORTS
//  i_clk            in   1    system clock
//  i_rst            in   1    synchronous active-high reset
//  i_req_valid      in   1    request presented this cycle (same cycle it reaches the address encoder)
//  i_object_id      in   game_pkg::ObjectID  object being fetched
//  i_pixel_index    in   MAP_H_WIDTH+MAP_V_WIDTH  pixel index within the object; only [1:0] is used here
//  i_flush          in   1    drop all in-flight requests (frame/scene change)
//  i_sram_dq        in   16   SRAM read data
//  o_pixel_valid    out  1    output pixel valid
//  o_object_id      out  game_pkg::ObjectID  id of the output pixel
//  o_palette_idx    out  4    extracted nibble
//  o_transparent    out  1    nibble==TRANSPARENT_IDX, object is a sprite, and the pixel is valid
//  o_rgb            out  24   palette colour; 24'h0 when transparent or not valid
// BEHAVIOUR
//  - Reset (i_rst high at posedge): every output goes to 0, o_object_id goes to OBJECT_MAP, and all
//    pipeline valids clear. Reset takes priority over every other input.
//  - Alignment pipeline: shift register of depth DQ_DELAY carrying {valid, object_id, pixel_index[1:0]}.
//    The stage leaving at cycle t+DQ_DELAY is paired with i_sram_dq sampled in that same cycle.
//  - Output register: a request accepted at cycle t appears on the outputs in cycle t+DQ_DELAY+1.
//    Default latency is 2. Throughput is 1 pixel/clk, with no back-pressure.
//  - Nibble select: sel = pixel_index[1:0], applied according to NIBBLE_MSB_FIRST.
//  - Transparency applies to PLAYERx, PLAYERx_SHIELD, PLAYERx_SQUAT, BULLETx, WIN/LOSE/START_CAPTION.
//    MAP, IDLE_BG and START_BG are always opaque: o_transparent=0, and the palette is applied even to
//    index 0.
//  - Palette: combinational lookup of (palette_sel(object_id), nibble) -> rgb, registered with the
//    other outputs. Player1 objects and bullet1 use the P1 palette. Player2 objects and bullet2 use P2.
//    Captions use CAPTION. MAP and the backgrounds use BG.
//  - An unlisted or undefined object_id produces o_rgb=0 and o_transparent=1, with o_pixel_valid
//    still asserted.
//  - i_flush: at the next posedge, all in-flight stage valids and o_pixel_valid clear.
//    A request presented in the same cycle as i_flush is also dropped, so flush wins.
//    Requests after flush deassert are processed normally.
//  - When o_pixel_valid=0, data outputs hold their last values except o_rgb=0 and o_transparent=0.
//  - Back-to-back requests with any object-id mix are independent; there is no word reuse or caching.
//  - Reset mid-stream: no output valid is produced for requests accepted before reset, and none for
//    requests accepted during reset.
// STRUCTURE
//  - game_pkg: add typedef enum PaletteSel {PAL_BG, PAL_P1, PAL_P2, PAL_CAPTION}, and the function
//    palette_sel(ObjectID).
//  - sram_pkg: add SRAM_DATA_WIDTH=16, PIXEL_BITS=4, PIXELS_PER_WORD=4, and the palette constant
//    arrays PALETTE[PaletteSel][16] of 24 bits.
//  - Sub-module pixel_palette_lut: purely combinational, (PaletteSel, [3:0] idx) -> [23:0] rgb.
//  - This module keeps the alignment shift register, nibble mux, transparency logic and output
//    register.
// TESTING
//  1. Four requests, OBJECT_PLAYER1, idx 0..3, dq=16'hA5C3 at each t+1 (NIBBLE_MSB_FIRST=0):
//     nibbles are 3,C,5,A. Each output appears at t+2, and nibble 3 gives o_rgb=PALETTE[P1][3].
//  2. OBJECT_BULLET2 with dq=16'h0000, idx 2: o_transparent=1 and o_rgb=0.
//     The same with OBJECT_START_BG: o_transparent=0 and o_rgb=PALETTE[BG][0].
//  3. Requests every cycle for 8 cycles, alternating PLAYER1 and MAP: 8 consecutive valids with
//     correct ids and colours, and no bubbles.
//  4. Request at t, i_flush at t+1: no o_pixel_valid at t+2. A request at t+2 gives valid at t+4.
//  5. Assert i_rst while 2 requests are in flight: all outputs are 0 the next cycle, and no valid is
//     produced for those requests.
//  6. NIBBLE_MSB_FIRST=1, dq=16'h1234, idx 0..3: nibbles are 1,2,3,4.

Source files
------------

// File: rtl/sram_pixel_decoder_pkg.sv
// Shared types and constants for the SRAM pixel read path: object ids,
// palette selection, SRAM word geometry and the colour tables.
package sram_pixel_decoder_pkg;

    localparam int MAP_H_WIDTH       = 8;
    localparam int MAP_V_WIDTH       = 8;
    localparam int PIXEL_INDEX_WIDTH = MAP_H_WIDTH + MAP_V_WIDTH;

    localparam int SRAM_DATA_WIDTH   = 16;
    localparam int PIXEL_BITS        = 4;
    localparam int PIXELS_PER_WORD   = 4;
    localparam int RGB_WIDTH         = 24;

    // Codes 14 and 15 are left undefined on purpose.
    typedef enum logic [3:0] {
        OBJECT_MAP            = 4'd0,
        OBJECT_IDLE_BG        = 4'd1,
        OBJECT_START_BG       = 4'd2,
        OBJECT_PLAYER1        = 4'd3,
        OBJECT_PLAYER1_SHIELD = 4'd4,
        OBJECT_PLAYER1_SQUAT  = 4'd5,
        OBJECT_PLAYER2        = 4'd6,
        OBJECT_PLAYER2_SHIELD = 4'd7,
        OBJECT_PLAYER2_SQUAT  = 4'd8,
        OBJECT_BULLET1        = 4'd9,
        OBJECT_BULLET2        = 4'd10,
        OBJECT_WIN_CAPTION    = 4'd11,
        OBJECT_LOSE_CAPTION   = 4'd12,
        OBJECT_START_CAPTION  = 4'd13
    } ObjectID;

    typedef enum logic [1:0] {PAL_BG, PAL_P1, PAL_P2, PAL_CAPTION} PaletteSel;

    // Opaque objects never go transparent; unknown ids are forced transparent.
    typedef enum logic [1:0] {OBJ_OPAQUE, OBJ_SPRITE, OBJ_UNKNOWN} ObjClass;

    function automatic PaletteSel palette_sel(input ObjectID id);
        case (id)
            OBJECT_PLAYER1, OBJECT_PLAYER1_SHIELD, OBJECT_PLAYER1_SQUAT,
            OBJECT_BULLET1:                                  return PAL_P1;
            OBJECT_PLAYER2, OBJECT_PLAYER2_SHIELD, OBJECT_PLAYER2_SQUAT,
            OBJECT_BULLET2:                                  return PAL_P2;
            OBJECT_WIN_CAPTION, OBJECT_LOSE_CAPTION,
            OBJECT_START_CAPTION:                            return PAL_CAPTION;
            default:                                         return PAL_BG;
        endcase
    endfunction

    function automatic ObjClass object_class(input ObjectID id);
        case (id)
            OBJECT_MAP, OBJECT_IDLE_BG, OBJECT_START_BG:     return OBJ_OPAQUE;
            OBJECT_PLAYER1, OBJECT_PLAYER1_SHIELD, OBJECT_PLAYER1_SQUAT,
            OBJECT_PLAYER2, OBJECT_PLAYER2_SHIELD, OBJECT_PLAYER2_SQUAT,
            OBJECT_BULLET1, OBJECT_BULLET2,
            OBJECT_WIN_CAPTION, OBJECT_LOSE_CAPTION,
            OBJECT_START_CAPTION:                            return OBJ_SPRITE;
            default:                                         return OBJ_UNKNOWN;
        endcase
    endfunction

    // Indexed [PaletteSel][nibble]; row order follows the PaletteSel encoding.
    localparam logic [RGB_WIDTH-1:0] PALETTE [4][16] = '{
        '{24'h000000, 24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h666666, 24'h777777,
          24'h888888, 24'h999999, 24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD, 24'hEEEEEE, 24'hFFFFFF},
        '{24'h100000, 24'h200404, 24'h300808, 24'h400C0C, 24'h501010, 24'h601414, 24'h701818, 24'h801C1C,
          24'h902020, 24'hA02424, 24'hB02828, 24'hC02C2C, 24'hD03030, 24'hE03434, 24'hF03838, 24'hFF4040},
        '{24'h000010, 24'h040420, 24'h080830, 24'h0C0C40, 24'h101050, 24'h141460, 24'h181870, 24'h1C1C80,
          24'h202090, 24'h2424A0, 24'h2828B0, 24'h2C2CC0, 24'h3030D0, 24'h3434E0, 24'h3838F0, 24'h4040FF},
        '{24'h101000, 24'h202000, 24'h303000, 24'h404000, 24'h505000, 24'h606000, 24'h707000, 24'h808000,
          24'h909000, 24'hA0A000, 24'hB0B000, 24'hC0C000, 24'hD0D000, 24'hE0E000, 24'hF0F000, 24'hFFFF80}
    };

endpackage

// File: rtl/sram_pixel_decoder_palette_lut.sv
// Combinational palette lookup: (palette, nibble) -> 24-bit RGB.
module pixel_palette_lut
    import sram_pixel_decoder_pkg::*;
(
    input  PaletteSel                pal_sel_i,
    input  logic [PIXEL_BITS-1:0]    idx_i,
    output logic [RGB_WIDTH-1:0]     rgb_o
);

    assign rgb_o = PALETTE[pal_sel_i][idx_i];

endmodule

// File: rtl/sram_pixel_decoder.sv
// Aligns in-flight request tags with the returning SRAM word, extracts the
// addressed nibble, applies transparency and palette, and registers the pixel.
module sram_pixel_decoder
    import sram_pixel_decoder_pkg::*;
#(
    parameter int              DQ_DELAY         = 1,
    parameter bit              NIBBLE_MSB_FIRST = 1'b0,
    parameter logic [3:0]      TRANSPARENT_IDX  = 4'h0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_req_valid,
    input  ObjectID                      i_object_id,
    input  logic [PIXEL_INDEX_WIDTH-1:0] i_pixel_index,
    input  logic                         i_flush,
    input  logic [SRAM_DATA_WIDTH-1:0]   i_sram_dq,
    output logic                         o_pixel_valid,
    output ObjectID                      o_object_id,
    output logic [PIXEL_BITS-1:0]        o_palette_idx,
    output logic                         o_transparent,
    output logic [RGB_WIDTH-1:0]         o_rgb
);

    // Only the word-lane select bits of the pixel index matter on the read side.
    logic unused_pix_hi;
    assign unused_pix_hi = ^i_pixel_index[PIXEL_INDEX_WIDTH-1:2];

    logic [DQ_DELAY-1:0]       vld_pipe_q;
    ObjectID                   id_pipe_q  [DQ_DELAY];
    logic [DQ_DELAY-1:0][1:0]  sel_pipe_q;

    // Valid shift register: flush and reset kill everything in flight, including the incoming request.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= i_req_valid;
            for (int i = 1; i < DQ_DELAY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    // Tag shift register (data only, qualified by vld_pipe_q).
    always_ff @(posedge i_clk) begin
        id_pipe_q[0]  <= i_object_id;
        sel_pipe_q[0] <= i_pixel_index[1:0];
        for (int i = 1; i < DQ_DELAY; i++) begin
            id_pipe_q[i]  <= id_pipe_q[i-1];
            sel_pipe_q[i] <= sel_pipe_q[i-1];
        end
    end

    logic                    head_vld;
    ObjectID                 head_id;
    logic [1:0]              head_sel;
    logic [PIXEL_BITS-1:0]   nibble;
    ObjClass                 head_class;
    logic [RGB_WIDTH-1:0]    lut_rgb;
    logic                    transp_d;
    logic [RGB_WIDTH-1:0]    rgb_d;

    assign head_vld   = vld_pipe_q[DQ_DELAY-1];
    assign head_id    = id_pipe_q[DQ_DELAY-1];
    assign head_sel   = sel_pipe_q[DQ_DELAY-1];
    assign head_class = object_class(head_id);

    // Nibble mux over the word that is on the bus this cycle.
    always_comb begin
        nibble = '0;
        for (int k = 0; k < PIXELS_PER_WORD; k++) begin
            if (head_sel == 2'(k))
                nibble = NIBBLE_MSB_FIRST
                       ? i_sram_dq[SRAM_DATA_WIDTH-PIXEL_BITS*(k+1) +: PIXEL_BITS]
                       : i_sram_dq[PIXEL_BITS*k +: PIXEL_BITS];
        end
    end

    pixel_palette_lut u_lut (
        .pal_sel_i (palette_sel(head_id)),
        .idx_i     (nibble),
        .rgb_o     (lut_rgb)
    );

    // Unknown ids are always transparent; sprites only on the transparent index.
    always_comb begin
        transp_d = (head_class == OBJ_UNKNOWN) ||
                   ((head_class == OBJ_SPRITE) && (nibble == TRANSPARENT_IDX));
        rgb_d    = transp_d ? '0 : lut_rgb;
    end

    logic                    pix_vld_q;
    ObjectID                 pix_id_q;
    logic [PIXEL_BITS-1:0]   pix_idx_q;
    logic                    pix_transp_q;
    logic [RGB_WIDTH-1:0]    pix_rgb_q;

    // Output register: id/idx hold while idle, colour and transparency drop to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pix_vld_q    <= 1'b0;
            pix_id_q     <= OBJECT_MAP;
            pix_idx_q    <= '0;
            pix_transp_q <= 1'b0;
            pix_rgb_q    <= '0;
        end else if (head_vld && !i_flush) begin
            pix_vld_q    <= 1'b1;
            pix_id_q     <= head_id;
            pix_idx_q    <= nibble;
            pix_transp_q <= transp_d;
            pix_rgb_q    <= rgb_d;
        end else begin
            pix_vld_q    <= 1'b0;
            pix_transp_q <= 1'b0;
            pix_rgb_q    <= '0;
        end
    end

    assign o_pixel_valid = pix_vld_q;
    assign o_object_id   = pix_id_q;
    assign o_palette_idx = pix_idx_q;
    assign o_transparent = pix_transp_q;
    assign o_rgb         = pix_rgb_q;

endmodule

// File: tb/tb_sram_pixel_decoder.sv
// Randomized and directed bench for sram_pixel_decoder; two instances
// (LSB-first and MSB-first nibble order) share the same stimulus.
module tb_sram_pixel_decoder;
    import sram_pixel_decoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst, req_valid, flush;
    ObjectID                      object_id;
    logic [PIXEL_INDEX_WIDTH-1:0] pixel_index;
    logic [15:0]                  dq;

    logic        v_l, t_l, v_m, t_m;
    ObjectID     id_l, id_m;
    logic [3:0]  idx_l, idx_m;
    logic [23:0] rgb_l, rgb_m;

    sram_pixel_decoder #(.DQ_DELAY(1), .NIBBLE_MSB_FIRST(1'b0), .TRANSPARENT_IDX(4'h0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_object_id(object_id),
        .i_pixel_index(pixel_index), .i_flush(flush), .i_sram_dq(dq),
        .o_pixel_valid(v_l), .o_object_id(id_l), .o_palette_idx(idx_l),
        .o_transparent(t_l), .o_rgb(rgb_l)
    );

    sram_pixel_decoder #(.DQ_DELAY(1), .NIBBLE_MSB_FIRST(1'b1), .TRANSPARENT_IDX(4'h0)) u_dut_msb (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_object_id(object_id),
        .i_pixel_index(pixel_index), .i_flush(flush), .i_sram_dq(dq),
        .o_pixel_valid(v_m), .o_object_id(id_m), .o_palette_idx(idx_m),
        .o_transparent(t_m), .o_rgb(rgb_m)
    );

    typedef struct {
        logic        rv;
        ObjectID     id;
        logic [1:0]  sel;
        logic        fl;
        logic        rs;
        logic [15:0] dq;
    } in_t;

    in_t        h1, h2;          // inputs of the previous cycle and the one before
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    ObjectID    hold_id  [2];
    logic [3:0] hold_idx [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // 0 = always opaque, 1 = sprite, 2 = not a known object
    function automatic int kind_of(input ObjectID id);
        case (id)
            OBJECT_MAP, OBJECT_IDLE_BG, OBJECT_START_BG: return 0;
            OBJECT_PLAYER1, OBJECT_PLAYER1_SHIELD, OBJECT_PLAYER1_SQUAT, OBJECT_BULLET1,
            OBJECT_PLAYER2, OBJECT_PLAYER2_SHIELD, OBJECT_PLAYER2_SQUAT, OBJECT_BULLET2,
            OBJECT_WIN_CAPTION, OBJECT_LOSE_CAPTION, OBJECT_START_CAPTION: return 1;
            default: return 2;
        endcase
    endfunction

    // Row of PALETTE: 0 BG, 1 P1, 2 P2, 3 caption
    function automatic int row_of(input ObjectID id);
        case (id)
            OBJECT_PLAYER1, OBJECT_PLAYER1_SHIELD, OBJECT_PLAYER1_SQUAT, OBJECT_BULLET1: return 1;
            OBJECT_PLAYER2, OBJECT_PLAYER2_SHIELD, OBJECT_PLAYER2_SQUAT, OBJECT_BULLET2: return 2;
            OBJECT_WIN_CAPTION, OBJECT_LOSE_CAPTION, OBJECT_START_CAPTION:               return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            logic        ev, et, av, at;
            ObjectID     eid, aid;
            logic [3:0]  eidx, aidx, n;
            logic [23:0] ergb, argb;
            int          sh;
            if (h1.rs) begin
                ev = 0; eid = OBJECT_MAP; eidx = 0; et = 0; ergb = 0;
            end else if (h2.rv && !h2.fl && !h2.rs && !h1.fl) begin
                sh = (m == 1) ? 12 - 4 * int'(h2.sel) : 4 * int'(h2.sel);
                n  = 4'((h1.dq >> sh) & 16'hF);
                ev = 1; eid = h2.id; eidx = n;
                if (kind_of(h2.id) == 2 || (kind_of(h2.id) == 1 && n == 4'h0)) begin
                    et = 1; ergb = 0;
                end else begin
                    et = 0; ergb = PALETTE[row_of(h2.id)][n];
                end
            end else begin
                ev = 0; eid = hold_id[m]; eidx = hold_idx[m]; et = 0; ergb = 0;
            end
            hold_id[m]  = eid;
            hold_idx[m] = eidx;
            av   = (m == 1) ? v_m   : v_l;
            aid  = (m == 1) ? id_m  : id_l;
            aidx = (m == 1) ? idx_m : idx_l;
            at   = (m == 1) ? t_m   : t_l;
            argb = (m == 1) ? rgb_m : rgb_l;
            check($sformatf("valid[%0d]", m),  32'(av),   32'(ev));
            check($sformatf("objid[%0d]", m),  32'(aid),  32'(eid));
            check($sformatf("palidx[%0d]", m), 32'(aidx), 32'(eidx));
            check($sformatf("transp[%0d]", m), 32'(at),   32'(et));
            check($sformatf("rgb[%0d]", m),    32'(argb), 32'(ergb));
        end
    endtask

    // One clock cycle: apply inputs after the edge, check the registered outputs at the negedge.
    task automatic drive(input logic rv, input ObjectID id, input logic [15:0] pidx,
                         input logic fl, input logic rs, input logic [15:0] d);
        @(posedge clk);
        #1;
        cyc++;
        req_valid = rv; object_id = id; pixel_index = pidx; flush = fl; rst = rs; dq = d;
        @(negedge clk);
        check_outputs();
        h2 = h1;
        h1 = '{rv, id, pidx[1:0], fl, rs, d};
    endtask

    task automatic idle(input logic [15:0] d);
        drive(1'b0, OBJECT_MAP, 16'h0, 1'b0, 1'b0, d);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; object_id = OBJECT_MAP;
        pixel_index = '0; dq = '0;
        h1 = '{1'b0, OBJECT_MAP, 2'd0, 1'b0, 1'b1, 16'h0};
        h2 = h1;

        // Reset held for a few cycles, requests presented during reset are dropped
        drive(1'b1, OBJECT_PLAYER1, 16'h1, 1'b0, 1'b1, 16'hFFFF);
        drive(1'b1, OBJECT_PLAYER2, 16'h2, 1'b0, 1'b1, 16'hFFFF);
        idle(16'h0);
        idle(16'h0);

        // Four nibbles of one word, LSB-first 3,C,5,A / MSB-first A,5,C,3
        for (int i = 0; i < 4; i++) drive(1'b1, OBJECT_PLAYER1, 16'(i), 1'b0, 1'b0, 16'hA5C3);
        idle(16'hA5C3);
        idle(16'h0);

        // Transparent sprite vs opaque background on a zero word
        drive(1'b1, OBJECT_BULLET2,  16'h2, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, OBJECT_START_BG, 16'h2, 1'b0, 1'b0, 16'h0000);
        idle(16'h0000);
        idle(16'h0);

        // Eight back-to-back requests alternating PLAYER1 / MAP
        for (int i = 0; i < 8; i++)
            drive(1'b1, (i % 2) ? OBJECT_MAP : OBJECT_PLAYER1, 16'($urandom), 1'b0, 1'b0, 16'($urandom));
        idle(16'($urandom));
        idle(16'h0);

        // Flush one cycle after a request, then a fresh request
        drive(1'b1, OBJECT_PLAYER2, 16'h1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, OBJECT_MAP,     16'h0, 1'b1, 1'b0, 16'h7777);
        drive(1'b1, OBJECT_PLAYER1, 16'h1, 1'b0, 1'b0, 16'h0);
        idle(16'h4321);
        idle(16'h0);
        // Request presented together with flush is dropped
        drive(1'b1, OBJECT_PLAYER1, 16'h0, 1'b1, 1'b0, 16'h0);
        idle(16'h9999);
        idle(16'h0);

        // Reset with two requests in flight
        drive(1'b1, OBJECT_PLAYER1, 16'h0, 1'b0, 1'b0, 16'h0);
        drive(1'b1, OBJECT_PLAYER2, 16'h1, 1'b0, 1'b1, 16'hBEEF);
        idle(16'hBEEF);
        idle(16'h0);

        // Nibble order word 1234, plus undefined ids
        for (int i = 0; i < 4; i++) drive(1'b1, OBJECT_WIN_CAPTION, 16'(i), 1'b0, 1'b0, 16'h1234);
        drive(1'b1, ObjectID'(4'd14), 16'h0, 1'b0, 1'b0, 16'h1234);
        drive(1'b1, ObjectID'(4'd15), 16'h3, 1'b0, 1'b0, 16'h5678);
        idle(16'h9ABC);
        idle(16'h0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  ObjectID'(4'($urandom_range(0, 15))),
                  16'($urandom),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 49) == 0),
                  16'($urandom));
        end
        idle(16'h0);
        idle(16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
